// File: rtl/and_chain_pkg.sv
// and_chain_pkg: mode encodings and the bitwise operator shared by every stage
package and_chain_pkg;
  localparam logic [1:0] MODE_AND  = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_PASS = 2'd3;
  // Operates on one bit so any WIDTH can be built by applying it per bit.
  function automatic logic op(input logic acc, input logic b, input logic [1:0] md);
    return md == MODE_AND ? acc & b :
           md == MODE_OR  ? acc | b :
           md == MODE_XOR ? acc ^ b : acc;
  endfunction
endpackage

// File: rtl/and_chain_stage.sv
// and_chain_stage: one registered operator stage with valid/ready hand-off
// clk, rst: clock and synchronous active-high reset
// prev_vld/prev_acc/prev_b/prev_md: upstream stage contents (or block inputs for stage 0)
// next_rdy: downstream stage ready; rdy: this stage can take data this cycle
// vld/acc/b/md: registered contents of this stage
module and_chain_stage
  import and_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_acc,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [1:0]       prev_md,
  input  logic             next_rdy,
  output logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       md
);
  logic             load;
  logic [WIDTH-1:0] nxt;
  assign rdy  = ~vld | next_rdy;
  assign load = prev_vld & rdy;
  always_comb begin
    nxt = '0;
    for (int i = 0; i < WIDTH; i++) nxt[i] = op(prev_acc[i], prev_b[i], prev_md);
  end
  // Without a new load, a stage whose item moves downstream becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      acc <= '0;
      b   <= '0;
      md  <= MODE_AND;
    end else if (load) begin
      vld <= 1'b1;
      acc <= nxt;
      b   <= prev_b;
      md  <= prev_md;
    end else if (next_rdy) begin
      vld <= 1'b0;
    end
  end
endmodule

// File: rtl/and_chain_pipe.sv
// and_chain_pipe: DEPTH-stage pipelined chain O = op(...op(op(A,B),B)...,B) with valid/ready
// CLK, RESET: clock and synchronous active-high reset
// in_valid/in_ready, A, B, mode: input transaction and its handshake
// out_valid/out_ready, O: result and its handshake
module and_chain_pipe
  import and_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O
);
  // Index 0 is the block input; index k+1 is the output of stage k.
  logic [DEPTH:0]            vld;
  logic [DEPTH:0]            rdy;
  logic [DEPTH:0][WIDTH-1:0] acc;
  logic [DEPTH:0][WIDTH-1:0] b;
  logic [DEPTH:0][1:0]       md;
  assign vld[0]     = in_valid;
  assign acc[0]     = A;
  assign b[0]       = B;
  assign md[0]      = mode;
  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0];
  assign out_valid  = vld[DEPTH];
  assign O          = acc[DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    and_chain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (CLK),
      .rst      (RESET),
      .prev_vld (vld[k]),
      .prev_acc (acc[k]),
      .prev_b   (b[k]),
      .prev_md  (md[k]),
      .next_rdy (rdy[k+1]),
      .rdy      (rdy[k]),
      .vld      (vld[k+1]),
      .acc      (acc[k+1]),
      .b        (b[k+1]),
      .md       (md[k+1])
    );
  end
endmodule

// File: tb/tb_and_chain_pipe.sv
// tb_and_chain_pipe: scoreboard bench for and_chain_pipe with directed and random traffic
module tb_and_chain_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       mode = 2'd0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] o;
  int               checks = 0;
  int               fails = 0;
  int               emitted = 0;
  logic [WIDTH-1:0] q[$];
  logic             stall_prev = 1'b0;

  always #5 clk = ~clk;

  and_chain_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O         (o)
  );

  // Closed-form result: AND/OR are idempotent, XOR cancels in pairs, PASS keeps A.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                             input logic [1:0] m);
    case (m)
      2'd0:    return av & bv;
      2'd1:    return av | bv;
      2'd2:    return (DEPTH % 2 == 1) ? av ^ bv : av;
      default: return av;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshakes seen at a negedge complete on the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) chk("hold_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out: O=%0h presented, expected no output", o);
        end else begin
          chk("out_data", 32'(o), 32'(q[0]));
          if (out_ready) begin
            void'(q.pop_front());
            emitted <= emitted + 1;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, mode));
      stall_prev <= out_valid & ~out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic [1:0] m);
    logic ok;
    in_valid = 1'b1;
    a = av;
    b = bv;
    mode = m;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic consec(input string name, input int n);
    int cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt = 1;
        break;
      end
    end
    if (cnt == 1) repeat (n - 1) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk(name, 32'(cnt), 32'(n));
    tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int e;
    int cnt;
    logic ok;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_o", 32'(o), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    // Latency: visible DEPTH-1 edges after the accepting edge, O idle at 0 before.
    send(8'hF3, 8'h3C, 2'd0);
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i < DEPTH - 1) begin
        chk("lat_idle_valid", 32'(out_valid), 32'd0);
        chk("lat_idle_o", 32'(o), 32'd0);
      end else begin
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_o", 32'(o), 32'h30);
      end
    end
    tick();
    drain();
    send(8'hA5, 8'hFF, 2'd2);
    send(8'h12, 8'h34, 2'd2);
    send(8'h00, 8'h01, 2'd2);
    in_valid = 1'b0;
    consec("xor_consec", 3);
    drain();
    send(8'h0F, 8'hF0, 2'd1);
    send(8'h55, 8'hAA, 2'd3);
    send(8'hFF, 8'h81, 2'd0);
    in_valid = 1'b0;
    consec("mode_consec", 3);
    drain();
    // Bubble collapse, then backpressure on a full pipe.
    out_ready = 1'b0;
    send(8'($urandom), 8'($urandom), 2'($urandom));
    in_valid = 1'b0;
    repeat (DEPTH + 1) tick();
    chk("bubble_last", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      a = 8'($urandom);
      b = 8'($urandom);
      mode = 2'($urandom);
      if (!ok) break;
      n++;
    end
    chk("bubble_accepts", 32'(n), 32'(DEPTH - 1));
    repeat (6) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_accept", 32'(in_ready), 32'd1);
    cnt = int'(out_valid);
    tick();
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(out_valid);
    end
    chk("release_consec", 32'(cnt), 32'd4);
    tick();
    drain();
    // Reset with three items in flight discards them.
    send(8'h11, 8'h22, 2'd1);
    send(8'h33, 8'h44, 2'd2);
    send(8'h55, 8'h66, 2'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_o", 32'(o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    e = emitted;
    tick();
    repeat (DEPTH + 2) tick();
    chk("midrst_no_emit", 32'(emitted), 32'(e));
    repeat (400) begin
      in_valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      mode = 2'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      tick();
    end
    rst = 1'b0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
